jt7759_seq: RTL and testbench

- Play-request sequencer for a jt7759 ADPCM core running in stand-alone mode (mdn=1).
- Accepts sample numbers from the sound CPU or a sound latch, and queues them in a small FIFO.
- For each queued sample it presents the number on the chip's din, pulses stn low, then tracks busyn through the whole playback.
- Sits between the CPU-side latch logic and the jt7759 instance. It reports completion, timeout and overflow events back to the CPU side.

---
 rtl/jt7759_seq.sv | 156 +++++++++++++++
 tb/tb_jt7759_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_seq.sv
// Play-request sequencer for a jt7759 in stand-alone mode: queues sample numbers,
// drives din/stn for each one and follows busyn until the sample finishes.
module jt7759_seq #(
    parameter int QW   = 2,
    parameter int STW  = 2,
    parameter int TOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          req,
    input  logic [7:0]    req_code,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [QW:0]   level,
    output logic          ovf,
    output logic          playing,
    output logic          done,
    output logic          tout,
    output logic          chip_cs,
    output logic          chip_mdn,
    output logic          chip_stn,
    output logic [7:0]    chip_din,
    input  logic          chip_busyn
);
    localparam int DEPTH = 1 << QW;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAITB, PLAY, GAP} st_t;

    st_t            st_q, st_d;
    logic [7:0]     mem_q [DEPTH];
    logic [QW-1:0]  wr_q, rd_q;
    logic [QW:0]    lvl_q, lvl_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     din_q, din_d;
    logic           ovf_q, done_q, done_d, tout_q, tout_d;
    logic           pop, push, ovf_d;

    assign full     = (lvl_q == (QW+1)'(DEPTH));
    assign empty    = (lvl_q == '0);
    assign level    = lvl_q;
    assign ovf      = ovf_q;
    assign done     = done_q;
    assign tout     = tout_q;
    assign playing  = (st_q == START) || (st_q == WAITB) || (st_q == PLAY);
    assign chip_cs  = 1'b1;
    assign chip_mdn = 1'b1;
    assign chip_stn = (st_q != START);
    assign chip_din = din_q;

    // A pop frees a slot in the same cycle, so a push while full is still accepted.
    assign push  = req && !flush && (!full || pop);
    assign ovf_d = req && !flush && full && !pop;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        din_d  = din_q;
        done_d = 1'b0;
        tout_d = 1'b0;
        pop    = 1'b0;
        case (st_q)
            IDLE: if (!empty && !flush) begin
                pop   = 1'b1;
                din_d = mem_q[rd_q];
                cnt_d = '0;
                st_d  = LOAD;
            end
            LOAD: begin
                if (flush)    st_d = IDLE;
                else if (cen) begin
                    st_d  = START;
                    cnt_d = '0;
                end
            end
            START: begin
                if (flush) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else if (cen) begin
                    if (cnt_q == 8'(STW - 1)) begin
                        st_d  = WAITB;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            // busyn low is checked first so it wins over a coincident timeout
            WAITB: if (cen) begin
                if (!chip_busyn) begin
                    st_d  = PLAY;
                    cnt_d = '0;
                end else if (cnt_q == 8'(TOUT - 1)) begin
                    tout_d = 1'b1;
                    st_d   = IDLE;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PLAY: if (cen && chip_busyn) begin
                done_d = 1'b1;
                st_d   = GAP;
            end
            GAP:     if (cen) st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        lvl_d = lvl_q;
        if (flush) lvl_d = '0;
        else begin
            case ({push, pop})
                2'b10:   lvl_d = lvl_q + 1'b1;
                2'b01:   lvl_d = lvl_q - 1'b1;
                default: lvl_d = lvl_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= req_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            cnt_q  <= '0;
            din_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            tout_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            din_q  <= din_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            tout_q <= tout_d;
            if (flush) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jt7759_seq.sv
// Bench for jt7759_seq: per-clock vector table with manual cen, then timed
// scenarios with a free-running cen and a busyn stub standing in for the chip.
module tb_jt7759_seq;
    logic       clk = 0, rst = 1, req = 0, flush = 0;
    logic [7:0] req_code = 0;
    logic       cen_tab = 0, cen_gen = 0, busyn_tab = 1, busyn_stub = 1;
    logic       cen_auto = 0, stub_en = 0, stub_hold = 0, stub_none = 0;
    int         stub_len = 5;
    logic       cen, chip_busyn;
    logic       full, empty, ovf, playing, done, tout, chip_cs, chip_mdn, chip_stn;
    logic [2:0] level;
    logic [7:0] chip_din;

    assign cen        = cen_auto ? cen_gen : cen_tab;
    assign chip_busyn = stub_en ? busyn_stub : busyn_tab;

    jt7759_seq #(.QW(2), .STW(2), .TOUT(16)) dut (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .req_code(req_code), .flush(flush),
        .full(full), .empty(empty), .level(level), .ovf(ovf), .playing(playing),
        .done(done), .tout(tout), .chip_cs(chip_cs), .chip_mdn(chip_mdn),
        .chip_stn(chip_stn), .chip_din(chip_din), .chip_busyn(chip_busyn)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor, cen generator (one tick every 4 clk) and busyn stub.
    int tick = 0, fall_tick = 0, rise_tick = 0, brise_tick = 0, stub_cnt = 100000, div = 0;
    int done_cnt = 0, tout_cnt = 0, ovf_cnt = 0;
    bit have_brise = 0;
    logic prev_stn = 1, prev_busy = 1;
    logic [7:0] played[$];
    int widths[$], tdelta[$], gaps[$];

    always @(negedge clk) begin
        if (cen) tick++;
        if (prev_stn && !chip_stn) begin
            played.push_back(chip_din);
            fall_tick = tick;
            if (have_brise) gaps.push_back(tick - brise_tick);
        end
        if (!prev_stn && chip_stn) begin
            widths.push_back(tick - fall_tick);
            rise_tick = tick;
            stub_cnt  = 0;
        end else if (cen && stub_cnt < 100000) stub_cnt++;
        if (done) done_cnt++;
        if (tout) begin
            tout_cnt++;
            tdelta.push_back(tick - rise_tick);
        end
        if (ovf) ovf_cnt++;
        prev_stn = chip_stn;
        if (stub_hold)      busyn_stub = 1'b0;
        else if (stub_none) busyn_stub = 1'b1;
        else                busyn_stub = !(stub_cnt >= 2 && stub_cnt < 2 + stub_len);
        if (stub_en && busyn_stub && !prev_busy) begin
            brise_tick = tick;
            have_brise = 1;
        end
        prev_busy = stub_en ? busyn_stub : 1'b1;
        div = (div + 1) % 4;
        cen_gen = (div == 0);
    end

    function automatic logic [31:0] pq(input int i);
        return (i >= 0 && i < played.size()) ? 32'(played[i]) : 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic       r, c, q;
        logic [7:0] cd;
        logic       f, b;
        logic [2:0] l;
        logic       fu, em, ov, pl, st, dn;
        logic [7:0] d;
    } vec_t;

    function automatic vec_t v(input logic r, c, q, input logic [7:0] cd, input logic f, b,
                               input logic [2:0] l, input logic fu, em, ov, pl, st, dn,
                               input logic [7:0] d);
        vec_t x;
        x.r = r; x.c = c; x.q = q; x.cd = cd; x.f = f; x.b = b;
        x.l = l; x.fu = fu; x.em = em; x.ov = ov; x.pl = pl; x.st = st; x.dn = dn; x.d = d;
        return x;
    endfunction

    task automatic pulse_rst();
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
    endtask

    task automatic push(input logic [7:0] c);
        req = 1; req_code = c; @(negedge clk); req = 0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic wait_done(input int n, input string nm);
        int b = 0;
        while (done_cnt < n && b < 20000) begin @(negedge clk); b++; end
        chk(nm, 32'(done_cnt >= n), 1);
    endtask

    task automatic flush_pulse();
        flush = 1; @(negedge clk); flush = 0;
    endtask

    vec_t tv[$];
    int d0, t0, o0, p0, w0, g0, b;

    initial begin
        //            r  c  q  code  f  b   lvl fu em ov pl st dn din
        tv.push_back(v(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h00));
        tv.push_back(v(0, 0, 1, 8'h03, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h11, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h22, 0, 1, 2, 0, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h33, 0, 1, 3, 0, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h44, 0, 1, 4, 1, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h55, 0, 1, 4, 1, 0, 1, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 1, 4, 1, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 0, 0, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 0, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h66, 0, 1, 4, 1, 0, 1, 1, 0, 0, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 1, 0, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 0, 4, 1, 0, 0, 1, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 1, 8'h77, 0, 0, 1, 0, 0, 0, 1, 1, 0, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 1, 1, 8'h03));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'h03));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h77));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 8'h77));
        tv.push_back(v(0, 0, 1, 8'h12, 1, 1, 0, 0, 1, 0, 0, 1, 0, 8'h77));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h77));
        tv.push_back(v(0, 0, 1, 8'h81, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'h77));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 0, 1, 8'h82, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 0, 1, 8'h83, 0, 1, 2, 0, 0, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 0, 1, 8'h84, 0, 1, 3, 0, 0, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 0, 1, 8'h85, 0, 1, 4, 1, 0, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 0, 0, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 0, 0, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 1, 1, 0, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 0, 4, 1, 0, 0, 1, 1, 0, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 0, 1, 1, 8'h81));
        tv.push_back(v(0, 1, 0, 8'h00, 0, 1, 4, 1, 0, 0, 0, 1, 0, 8'h81));
        tv.push_back(v(0, 0, 1, 8'h86, 0, 1, 4, 1, 0, 0, 0, 1, 0, 8'h82));
        tv.push_back(v(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 1, 0, 8'h00));

        repeat (2) @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst = tv[i].r; cen_tab = tv[i].c; req = tv[i].q; req_code = tv[i].cd;
            flush = tv[i].f; busyn_tab = tv[i].b;
            @(posedge clk); #1;
            chk($sformatf("vec%0d {full,empty,level,ovf,playing,stn,done,tout,din}", i),
                {14'd0, full, empty, level, ovf, playing, chip_stn, done, tout, chip_din},
                {14'd0, tv[i].fu, tv[i].em, tv[i].l, tv[i].ov, tv[i].pl, tv[i].st, tv[i].dn,
                 1'b0, tv[i].d});
        end
        @(negedge clk);
        rst = 0; req = 0; flush = 0; cen_tab = 0; busyn_tab = 1;
        cen_auto = 1; stub_en = 1;

        // Single request
        stub_len = 100; pulse_rst();
        d0 = done_cnt; t0 = tout_cnt; p0 = played.size(); w0 = widths.size();
        push(8'h03);
        wait_done(d0 + 1, "single_done_seen");
        wait_ticks(20);
        chk("single_nplay", played.size() - p0, 1);
        chk("single_din", pq(p0), 8'h03);
        chk("single_stn_width", (widths.size() > w0) ? widths[w0] : -1, 2);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_no_tout", tout_cnt - t0, 0);
        chk("single_idle", {playing, empty}, 2'b01);

        // Queue order
        stub_len = 5;
        d0 = done_cnt; p0 = played.size(); w0 = widths.size(); g0 = gaps.size();
        push(8'h01); push(8'h02); push(8'h03);
        wait_done(d0 + 3, "queue_done_seen");
        wait_ticks(20);
        chk("queue_done_cnt", done_cnt - d0, 3);
        chk("queue_nplay", played.size() - p0, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("queue_order%0d", i), pq(p0 + i), 32'(i + 1));
        for (int i = w0; i < widths.size(); i++) chk("queue_stn_width", widths[i], 2);
        for (int i = g0; i < gaps.size(); i++) chk("queue_gap_ge1", 32'(gaps[i] >= 1), 1);

        // Overflow with playback held
        d0 = done_cnt; p0 = played.size(); o0 = ovf_cnt;
        stub_hold = 1;
        push(8'h0F);
        wait_ticks(8);
        for (int i = 1; i <= 5; i++) push(8'h10 + 8'(i));
        @(negedge clk);
        chk("ovf_level", level, 4);
        chk("ovf_full", full, 1);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        stub_len = 3; stub_hold = 0;
        wait_done(d0 + 5, "ovf_done_seen");
        wait_ticks(30);
        chk("ovf_nplay", played.size() - p0, 5);
        chk("ovf_first", pq(p0), 8'h0F);
        for (int i = 1; i <= 4; i++) chk($sformatf("ovf_code%0d", i), pq(p0 + i), 32'(8'h10 + i));

        // Timeout: busyn never falls
        d0 = done_cnt; t0 = tout_cnt; p0 = played.size(); w0 = tdelta.size();
        stub_none = 1;
        push(8'h21); push(8'h22);
        b = 0;
        while (tout_cnt < t0 + 2 && b < 20000) begin @(negedge clk); b++; end
        wait_ticks(4);
        chk("tout_cnt", tout_cnt - t0, 2);
        chk("tout_no_done", done_cnt - d0, 0);
        for (int i = w0; i < tdelta.size(); i++) chk("tout_delay", tdelta[i], 16);
        chk("tout_next_starts", pq(p0 + 1), 8'h22);
        stub_none = 0;

        // Flush during START with two entries queued
        stub_len = 30;
        d0 = done_cnt; t0 = tout_cnt; p0 = played.size();
        push(8'h31); push(8'h32); push(8'h33);
        b = 0;
        while (chip_stn && b < 2000) begin @(negedge clk); b++; end
        chk("flushS_in_start", chip_stn, 0);
        flush_pulse();
        chk("flushS_stn_high", chip_stn, 1);
        chk("flushS_level", level, 0);
        chk("flushS_not_playing", playing, 0);
        wait_ticks(60);
        chk("flushS_nplay", played.size() - p0, 1);
        chk("flushS_no_done_tout", (done_cnt - d0) + (tout_cnt - t0), 0);

        // Flush during PLAY
        d0 = done_cnt; p0 = played.size();
        push(8'h41); push(8'h42);
        b = 0;
        while (!(playing && !chip_busyn) && b < 2000) begin @(negedge clk); b++; end
        wait_ticks(2);
        flush_pulse();
        chk("flushP_level", level, 0);
        wait_done(d0 + 1, "flushP_done_seen");
        wait_ticks(40);
        chk("flushP_done_cnt", done_cnt - d0, 1);
        chk("flushP_nplay", played.size() - p0, 1);

        // Reset during PLAY
        d0 = done_cnt; p0 = played.size();
        push(8'h51);
        b = 0;
        while (!(playing && !chip_busyn) && b < 2000) begin @(negedge clk); b++; end
        wait_ticks(2);
        rst = 1; @(negedge clk); rst = 0;
        chk("rst_outputs {lvl,full,empty,ovf,playing,done,tout,cs,mdn,stn,din}",
            {level, full, empty, ovf, playing, done, tout, chip_cs, chip_mdn, chip_stn, chip_din},
            {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
        wait_ticks(40);
        push(8'h00);
        wait_done(d0 + 1, "rst_replay_done");
        chk("rst_replay_code", pq(p0 + 1), 8'h00);
        chk("rst_no_extra_done", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
